// File: rtl/axi_lite_led_slave.sv
// axi_lite_led_slave: AXI4-Lite register file (pattern/ctrl/divider/scratch) driving a blink-gated LED bank
module axi_lite_led_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_LEDS = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_LEDS-1:0]             led
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  logic [DW-1:0] regs [4];
  logic [DW-1:0] w_data, cnt, wr_data, wr_mask;
  logic [DW/8-1:0] w_strb, wr_strb;
  logic [1:0] aw_idx, wr_idx;
  logic live, aw_held, w_held, phase;
  logic aw_hs, w_hs, ar_hs, commit, blink_on, blink_clr;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  // live keeps every ready low for the first cycle out of reset
  assign S_AXI_AWREADY = live & ~aw_held & ~S_AXI_BVALID;
  assign S_AXI_WREADY = live & ~w_held & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = live & ~S_AXI_RVALID;
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx = aw_held ? aw_idx : S_AXI_AWADDR[3:2];
  assign wr_data = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
  for (genvar g = 0; g < DW/8; g++) begin : g_mask
    assign wr_mask[8*g +: 8] = {8{wr_strb[g]}};
  end
  assign blink_on = regs[1][0] & (regs[2] != '0);
  // a commit to ctrl (1) or divider (2) restarts the blink from a lit phase
  assign blink_clr = commit & (wr_idx[1] ^ wr_idx[0]);
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      live <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      cnt <= '0;
      phase <= 1'b1;
      led <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      live <= 1'b1;
      if (commit) begin
        regs[wr_idx] <= (regs[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        aw_held <= 1'b0;
        w_held <= 1'b0;
        S_AXI_BVALID <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= S_AXI_WDATA;
          w_strb <= S_AXI_WSTRB;
        end
        if (S_AXI_BVALID & S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      end
      if (ar_hs) begin
        S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
        S_AXI_RVALID <= 1'b1;
      end else if (S_AXI_RVALID & S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      if (blink_clr | ~blink_on) begin
        cnt <= '0;
        phase <= 1'b1;
      end else if (cnt == regs[2]) begin
        cnt <= '0;
        phase <= ~phase;
      end else cnt <= cnt + DW'(1);
      led <= regs[0][NUM_LEDS-1:0] & {NUM_LEDS{phase}};
    end
endmodule

// File: tb/tb_axi_lite_led_slave.sv
// tb_axi_lite_led_slave: directed plus randomized checks of the LED register slave against a register-array model
module tb_axi_lite_led_slave;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [7:0] led;
  logic [31:0] mreg [4];
  logic [31:0] rd, hold;
  int total = 0, passed = 0, cyc = 0, commit_cyc = 0;
  bit early_b;

  axi_lite_led_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_LEDS(8)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // AW and W are raised after independent delays; returns on the negedge after the commit edge
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit aw_done = 1'b0, w_done = 1'b0, aw_go, w_go;
    int k;
    early_b = 1'b0;
    for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      early_b |= bvalid && !aw_done;
      awaddr = a;
      wdata = d;
      wstrb = s;
      awvalid = !aw_done && c >= aw_dly;
      wvalid = !w_done && c >= w_dly;
      aw_go = awvalid && awready;
      w_go = wvalid && wready;
      @(posedge clk);
      aw_done |= aw_go;
      w_done |= w_go;
    end
    @(negedge clk);
    commit_cyc = cyc;
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("wr_handshakes", {30'd0, aw_done, w_done}, 32'd3);
    for (k = 0; k < 20 && !bvalid; k++) @(negedge clk);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly = 0, input int w_dly = 0);
    axi_write(a, d, s, aw_dly, w_dly);
    for (int b = 0; b < 4; b++) if (s[b]) mreg[a[3:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int k;
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    for (k = 0; k < 20 && !arready; k++) @(negedge clk);
    check("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    for (k = 0; k < 20 && !rvalid; k++) @(negedge clk);
    check("rvalid", rvalid, 1);
    check("rresp", rresp, 0);
    d = rdata;
  endtask

  initial begin
    logic [1:0] idx;
    logic [3:0] s;
    logic [31:0] d;
    int dv;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_led", {24'd0, led}, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) wr(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("t1_readback", rd, 32'(i + 1));
    end
    check("t1_led", {24'd0, led}, 32'h01);

    wr(4'h0, 32'hA5, 4'hF, 3, 0);
    check("t2_no_early_b", {31'd0, early_b}, 0);
    @(negedge clk);
    check("t2_single_b", bvalid, 0);
    check("t2_led", {24'd0, led}, 32'hA5);

    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    wr(4'hC, 32'h1234_5678, 4'b0101);
    axi_read(4'hC, rd);
    check("t3_strobe", rd, 32'hFF34_FF78);

    dv = 3;
    wr(4'h0, 32'h0F, 4'hF);
    wr(4'h8, 32'(dv), 4'hF);
    wr(4'h4, 32'h1, 4'hF);
    // each phase lasts dv+1 cycles counted from the ctrl commit; led trails phase by one cycle
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      check("t4_blink", {24'd0, led}, (((cyc - commit_cyc - 1) / (dv + 1)) % 2 == 0) ? 32'h0F : 32'h00);
    end

    bready = 1'b0;
    wr(4'hC, 32'hCAFE_0001, 4'hF);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("t5_bvalid_held", bvalid, 1);
      check("t5_awready_low", awready, 0);
      check("t5_wready_low", wready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    check("t5_b_released", bvalid, 0);
    rready = 1'b0;
    axi_read(4'hC, hold);
    check("t5_rdata", hold, mreg[3]);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("t5_rvalid_held", rvalid, 1);
      check("t5_rdata_stable", rdata, hold);
      check("t5_arready_low", arready, 0);
    end
    rready = 1'b1;
    @(negedge clk);
    check("t5_r_released", rvalid, 0);

    for (int i = 0; i < 40; i++) begin
      idx = 2'($urandom_range(3));
      if ($urandom_range(1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(15));
        wr({idx, 2'($urandom_range(3))}, d, s, $urandom_range(3), $urandom_range(3));
      end else begin
        axi_read({idx, 2'($urandom_range(3))}, rd);
        check("rand_read", rd, mreg[idx]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("rand_final", rd, mreg[i]);
    end

    repeat (3) @(negedge clk);
    awaddr = 4'h0;
    awvalid = 1'b1;
    check("t6_awready", awready, 1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 32'hDEAD_BEEF;
    wstrb = 4'hF;
    wvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bvalid", bvalid, 0);
    check("t6_rst_led", {24'd0, led}, 0);
    check("t6_rst_wready", wready, 0);
    @(negedge clk);
    wvalid = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    repeat (3) @(negedge clk);
    check("t6_no_b", bvalid, 0);
    check("t6_led", {24'd0, led}, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), rd);
      check("t6_regs_zero", rd, mreg[i]);
    end
    wr(4'h8, 32'h5555_AAAA, 4'hF);
    axi_read(4'h8, rd);
    check("t6_write_after_rst", rd, 32'h5555_AAAA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
